// File: rtl/timer_capture_core_if.sv
// Control/status bundle between the timer register file (master) and one input-capture channel (slave).
interface timer_capture_core_if #(
  parameter int CNT_WIDTH  = 32,
  parameter int PSCR_WIDTH = 20,
  parameter int FILT_WIDTH = 4
);
  logic                  en_i;
  logic                  mode_i;
  logic [1:0]            edge_i;
  logic [PSCR_WIDTH-1:0] pscr_i;
  logic [FILT_WIDTH-1:0] filt_i;
  logic                  capie_i;
  logic                  ovie_i;
  logic                  clr_i;
  logic                  capch_i;
  logic [CNT_WIDTH-1:0]  cnt_o;
  logic [CNT_WIDTH-1:0]  cap_o;
  logic                  capif_o;
  logic                  ovr_o;
  logic                  ovif_o;
  logic                  irq_o;

  modport master (
    output en_i, mode_i, edge_i, pscr_i, filt_i, capie_i, ovie_i, clr_i, capch_i,
    input  cnt_o, cap_o, capif_o, ovr_o, ovif_o, irq_o
  );

  modport slave (
    input  en_i, mode_i, edge_i, pscr_i, filt_i, capie_i, ovie_i, clr_i, capch_i,
    output cnt_o, cap_o, capif_o, ovr_o, ovif_o, irq_o
  );
endinterface

// File: rtl/timer_capture_core.sv
// Input-capture channel: sync -> optional glitch filter -> edge detect -> latch prescaled timebase.
// Define TIMER_CAPTURE_FILTER_EN to insert the N+1-cycle digital filter ahead of edge detect.
module timer_capture_core #(
  parameter int CNT_WIDTH  = 32,
  parameter int PSCR_WIDTH = 20,
  parameter int FILT_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  timer_capture_core_if.slave  bus
);

  logic                  sync1_q, sync2_q, lvl_q, prev_q;
  logic                  lvl_d;
  logic [PSCR_WIDTH-1:0] div_q, div_d, plast;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cap_q, cap_d;
  logic                  capif_q, capif_d, ovr_q, ovr_d, ovif_q, ovif_d;
  logic                  rise, fall, edge_hit, cap_evt, tick, wrap;

`ifdef TIMER_CAPTURE_FILTER_EN
  logic                  filt_q, filt_d;
  logic [FILT_WIDTH-1:0] run_q, run_d;

  // Level flips only after N+1 consecutive disagreeing samples; any agreement restarts the run.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q == bus.filt_i) filt_d = sync2_q;
      else                     run_d  = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign lvl_d = filt_q;
`else
  assign lvl_d = sync2_q;
`endif

  assign plast = (bus.pscr_i < PSCR_WIDTH'(2)) ? PSCR_WIDTH'(1) : bus.pscr_i - 1'b1;
  // >= so that shrinking the ratio below the current div ticks on the next cycle
  assign tick  = bus.en_i & (div_q >= plast);
  assign wrap  = tick & (&cnt_q);

  assign rise = lvl_q & ~prev_q;
  assign fall = ~lvl_q & prev_q;

  always_comb begin
    case (bus.edge_i)
      2'b01:   edge_hit = fall;
      2'b10:   edge_hit = rise | fall;
      default: edge_hit = rise;
    endcase
  end

  assign cap_evt = bus.en_i & edge_hit;

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    capif_d = capif_q;
    ovr_d   = ovr_q;
    ovif_d  = ovif_q;
    if (!bus.en_i) begin
      div_d = '0;
      cnt_d = '0;
    end else if (cap_evt && bus.mode_i) begin
      div_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      div_d = '0;
      cnt_d = cnt_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
    // Clear first so a coincident capture or wrap wins.
    if (bus.clr_i) begin
      capif_d = 1'b0;
      ovr_d   = 1'b0;
      ovif_d  = 1'b0;
    end
    if (cap_evt) begin
      cap_d   = cnt_q;
      capif_d = 1'b1;
      if (capif_q) ovr_d = 1'b1;
    end
    if (wrap) ovif_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      capif_q <= 1'b0;
      ovr_q   <= 1'b0;
      ovif_q  <= 1'b0;
    end else begin
      sync1_q <= bus.capch_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      capif_q <= capif_d;
      ovr_q   <= ovr_d;
      ovif_q  <= ovif_d;
    end
  end

  assign bus.cnt_o   = cnt_q;
  assign bus.cap_o   = cap_q;
  assign bus.capif_o = capif_q;
  assign bus.ovr_o   = ovr_q;
  assign bus.ovif_o  = ovif_q;
  assign bus.irq_o   = (bus.capie_i & capif_q) | (bus.ovie_i & ovif_q);

endmodule

// File: doc/timer_capture_core.md
# timer_capture_core

Input-capture channel for the timer peripheral: the reading counterpart to the compare/output path. It samples the external `capch_i` pin, optionally glitch-filters it, detects the selected edge, and latches a prescaled free-running timebase into a capture register. Raises capture, overcapture and overflow flags and an `irq_o`. Sits beside the timer core behind the same APB4 register file; that register file drives its control inputs and reads its results.

## Interface
- `CNT_WIDTH`, 32, timebase and capture register width
- `PSCR_WIDTH`, 20, prescaler width
- `FILT_WIDTH`, 4, filter length field width
- `clk_i` in 1 — system clock; the only clock
- `rst_n_i` in 1 — asynchronous, active-low reset
- `en_i` in 1 — channel enable
- `mode_i` in 1 — 0 free-running; 1 reset-on-capture (period measurement)
- `edge_i` in 2 — 00 rising, 01 falling, 10 both, 11 treated as rising
- `pscr_i` in PSCR_WIDTH — divide ratio; values <2 are treated as 2
- `filt_i` in FILT_WIDTH — filter length N (see Configuration)
- `capie_i`, `ovie_i` in 1 — interrupt enables
- `clr_i` in 1 — one-cycle pulse; clears `capif_o`, `ovr_o`, `ovif_o`
- `capch_i` in 1 — asynchronous capture pin
- `cnt_o` out CNT_WIDTH — live timebase
- `cap_o` out CNT_WIDTH — last captured value
- `capif_o` out 1 — capture-occurred flag (sticky)
- `ovr_o` out 1 — overcapture flag (sticky)
- `ovif_o` out 1 — timebase wrap flag (sticky)
- `irq_o` out 1 — `(capie_i & capif_o) | (ovie_i & ovif_o)`, combinational from flops

## Operation
- Reset: all outputs and internal state 0, including sync, filter and previous-sample registers.
- Synchronizer: 2-FF on `capch_i`, always running, independent of `en_i`.
- Prescaler: `div` counts 0..P-1, P = max(`pscr_i`, 2); the tick occurs on the cycle `div`==P-1. On tick, `div`→0 and `cnt`→`cnt`+1.
- Wrap: a tick at `cnt` = all-ones sets `cnt`→0 and `ovif_o`=1.
- `en_i`=0: `div` and `cnt` are held at 0. Edge events are suppressed. Flags and `cap_o` are retained. The previous-sample register keeps tracking, so enabling while the pin is high gives no spurious rising edge.
- Edge detect compares the filtered sample against the previous sample and applies the `edge_i` selection.
- Capture event, with `en_i`=1:
  - `cap_o` ← current `cnt_o` value, i.e. the pre-increment/pre-reset value of that cycle.
  - If `capif_o` was already 1, `ovr_o`=1.
  - `capif_o`=1.
  - `mode_i`=1: `cnt` and `div` ← 0. This overrides a coincident tick; `ovif_o` is still set if that tick would have wrapped.
- Simultaneous `clr_i` and capture: the capture wins, so `capif_o`=1. `ovr_o` is then set only if `capif_o` was 1 before the cycle. Same rule applies to `clr_i` versus wrap for `ovif_o`.
- `pscr_i`/`mode_i`/`edge_i` changes take effect next cycle. If `div` ≥ new P-1, the next cycle ticks and `div` resets.

## Timing
- Pin change setup to edge k: synchronized at k+2, edge detected at k+3 (unfiltered build).
- `cap_o`/`capif_o` are updated at edge k+3 and visible after it. `irq_o` follows in the same cycle.
- Filtered build adds N+1 cycles (N = `filt_i`).
- Minimum resolvable pulse width: 3 cycles unfiltered; N+3 filtered.
- Mid-operation reset: everything returns to 0 asynchronously. No capture is reported for edges in flight.

## Configuration
- `TIMER_CAPTURE_FILTER_EN` defined:
  - Digital filter between the synchronizer and edge detect.
  - The filtered level changes only after the synced input differs from it for N+1 consecutive cycles; the run counter restarts on any bounce.
  - N=0 is a 1-cycle delay.
- Not defined:
  - The filter is absent; `filt_i` is ignored.
  - The synced level feeds edge detect directly.

## Test plan
- pscr_i=4, mode 0, en_i=1, rising edge after 40 cycles → `cnt_o`=10 at edge; `cap_o`=10, `capif_o`=1, `irq_o`=1 with capie_i=1, at edge+3.
- mode 1, pscr_i=2, square wave period 20 cycles, both edges → each capture reads 5, `cnt_o` restarts at 0; second capture without clr sets `ovr_o`=1.
- `cnt` forced near wrap (pscr_i=2, start 0xFFFF_FFFE via long run or force) → after tick, `cnt_o`=0, `ovif_o`=1, `irq_o`=1 with ovie_i=1.
- `clr_i` pulsed in the same cycle as a capture → `capif_o` stays 1, `ovr_o` stays 0.
- Filter build, filt_i=3: 3-cycle glitch → no capture; 6-cycle pulse → capture 4 cycles later than the unfiltered latency.
- capch_i high during reset, en_i raised later → no capture. Reset asserted mid-count → all outputs 0 immediately.
